// File: rtl/uart_packet_assembler.sv
// rtl/uart_packet_assembler.sv - assembles MSB-first UART bytes into {HEADER, loc, data, footer} packets
// and writes each validated packet into the input-image RAM.
module uart_packet_assembler #(
  parameter int          LOC_W       = 10,
  parameter int          DATA_W      = 8,
  parameter logic [2:0]  HEADER      = 3'b101,
  parameter int          NUM_WORDS   = 785,
  parameter int          TIMEOUT_CYC = 4096,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              wr_en,
  output logic [LOC_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_hdr_cnt,
  output logic [CNT_W-1:0]  err_ftr_cnt,
  output logic [CNT_W-1:0]  err_rng_cnt,
  output logic [CNT_W-1:0]  err_to_cnt,
  output logic              err_pulse,
  output logic              busy,
  output logic              frame_done
);

  localparam int PKT_W = 6 + LOC_W + DATA_W;
  localparam int NB    = PKT_W / 8;
  localparam int IDX_W = $clog2(NB + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NB - 1);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(NUM_WORDS - 1);
  localparam logic [31:0]      NUM_WORDS_U = NUM_WORDS;

  if (PKT_W % 8 != 0) begin : g_pkt_w_check
    $error("uart_packet_assembler: PKT_W must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t             state, state_nx;
  logic [PKT_W-1:0]   sr;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   tmr;
  logic               err_pend;

  logic               take_first, shift_en, tmr_inc;
  logic               hdr_err, to_err, ftr_err, rng_err, good_wr;

  logic [2:0]         pkt_hdr;
  logic [LOC_W-1:0]   pkt_loc;
  logic [DATA_W-1:0]  pkt_data;
  logic [2:0]         pkt_ftr;

  assign pkt_hdr  = sr[PKT_W-1 -: 3];
  assign pkt_loc  = sr[PKT_W-4 -: LOC_W];
  assign pkt_data = sr[DATA_W+2 -: DATA_W];
  assign pkt_ftr  = sr[2:0];

  function automatic logic [2:0] calc_ftr(input logic [LOC_W-1:0] l, input logic [DATA_W-1:0] d);
    calc_ftr = {^d, ^l, ^{d[DATA_W-1:DATA_W/2], l[LOC_W-1:LOC_W/2]}};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    take_first = 1'b0;
    shift_en   = 1'b0;
    tmr_inc    = 1'b0;
    hdr_err    = 1'b0;
    to_err     = 1'b0;
    ftr_err    = 1'b0;
    rng_err    = 1'b0;
    good_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_byte[7:5] == HEADER) begin
            take_first = 1'b1;
            state_nx   = COLLECT;
          end else begin
            hdr_err = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          shift_en = 1'b1;
          if (idx == IDX_LAST) state_nx = CHECK;
        end else if (tmr == TMR_LAST) begin
          to_err   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      CHECK: begin
        if (pkt_hdr != HEADER || pkt_ftr != calc_ftr(pkt_loc, pkt_data)) ftr_err = 1'b1;
        else if (32'(pkt_loc) >= NUM_WORDS_U)                               rng_err = 1'b1;
        else                                                                good_wr = 1'b1;
        // A frame that completes here swallows any byte arriving in the same cycle.
        if (good_wr && pkt_count == CNT_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = IDLE;
          if (in_valid) begin
            if (in_byte[7:5] == HEADER) begin
              take_first = 1'b1;
              state_nx   = COLLECT;
            end else begin
              hdr_err = 1'b1;
            end
          end
        end
      end
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr          <= '0;
      idx         <= '0;
      tmr         <= '0;
      err_pend    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      pkt_count   <= '0;
      err_hdr_cnt <= '0;
      err_ftr_cnt <= '0;
      err_rng_cnt <= '0;
      err_to_cnt  <= '0;
      err_pulse   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      err_pulse <= 1'b0;
      if (clear) begin
        idx         <= '0;
        tmr         <= '0;
        err_pend    <= 1'b0;
        pkt_count   <= '0;
        err_hdr_cnt <= '0;
        err_ftr_cnt <= '0;
        err_rng_cnt <= '0;
        err_to_cnt  <= '0;
      end else begin
        if (take_first) begin
          sr  <= PKT_W'(in_byte);
          idx <= IDX_W'(1);
          tmr <= '0;
        end else if (shift_en) begin
          sr  <= PKT_W'({sr, in_byte});
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          tmr <= '0;
        end else if (to_err) begin
          idx <= '0;
          tmr <= '0;
        end else if (tmr_inc) begin
          tmr <= tmr + TMR_W'(1);
        end
        if (hdr_err) err_hdr_cnt <= sat_inc(err_hdr_cnt);
        if (to_err)  err_to_cnt  <= sat_inc(err_to_cnt);
        if (ftr_err) err_ftr_cnt <= sat_inc(err_ftr_cnt);
        if (rng_err) err_rng_cnt <= sat_inc(err_rng_cnt);
        // A bad first byte landing on a good write is deferred one cycle so strobes never overlap.
        if (good_wr) begin
          wr_en     <= 1'b1;
          wr_addr   <= pkt_loc;
          wr_data   <= pkt_data;
          pkt_count <= sat_inc(pkt_count);
          err_pend  <= hdr_err;
        end else begin
          err_pulse <= hdr_err | to_err | ftr_err | rng_err | err_pend;
          err_pend  <= 1'b0;
        end
      end
    end
  end

  assign busy       = (state == COLLECT) || (state == CHECK);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_uart_packet_assembler.sv
// tb/tb_uart_packet_assembler.sv - randomized self-checking bench for uart_packet_assembler
module tb_uart_packet_assembler;

  localparam int         LOC_W     = 10;
  localparam int         DATA_W    = 8;
  localparam logic [2:0] HEADER    = 3'b101;
  localparam int         NUM_WORDS = 785;
  localparam int         TIMEOUT   = 4096;
  localparam int         CNT_W     = 16;
  localparam int         NB        = (6 + LOC_W + DATA_W) / 8;

  logic              clk = 1'b0;
  logic              rst, clear, in_valid;
  logic [7:0]        in_byte;
  logic              wr_en, err_pulse, busy, frame_done;
  logic [LOC_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  pkt_count, err_hdr_cnt, err_ftr_cnt, err_rng_cnt, err_to_cnt;

  uart_packet_assembler #(
    .LOC_W(LOC_W), .DATA_W(DATA_W), .HEADER(HEADER), .NUM_WORDS(NUM_WORDS),
    .TIMEOUT_CYC(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_byte(in_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pkt_count(pkt_count),
    .err_hdr_cnt(err_hdr_cnt), .err_ftr_cnt(err_ftr_cnt), .err_rng_cnt(err_rng_cnt),
    .err_to_cnt(err_to_cnt), .err_pulse(err_pulse), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp_v, exp_v);
    end
  endtask

  // Reference model: byte stream in, expected writes and counters out.
  logic [7:0]                cur[$];
  logic [LOC_W+DATA_W-1:0]   exp_wr[$];
  int exp_pkt, exp_hdr, exp_ftr, exp_rng, exp_to, exp_errs;
  bit done_m;
  int idle_cnt;
  int obs_err = 0;
  int err_base;

  function automatic int parity(input int v);
    return $countones(v) % 2;
  endfunction

  function automatic int footer_of(input int loc, input int data);
    return (parity(data) << 2) | (parity(loc) << 1) |
           ((parity(data >> (DATA_W/2)) + parity(loc >> (LOC_W/2))) % 2);
  endfunction

  function automatic int mk_pkt(input int loc, input int data, input int flip);
    int p;
    p = (int'(HEADER) << (LOC_W + DATA_W + 3)) | (loc << (DATA_W + 3)) | (data << 3) |
        footer_of(loc, data);
    if (flip >= 0) p = p ^ (1 << flip);
    return p;
  endfunction

  function automatic void model_reset();
    cur.delete();
    exp_wr.delete();
    exp_pkt = 0; exp_hdr = 0; exp_ftr = 0; exp_rng = 0; exp_to = 0; exp_errs = 0;
    done_m = 0;
    err_base = obs_err;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int idle);
    int p, loc, data, f;
    if (done_m) return;
    if (cur.size() > 0 && idle >= TIMEOUT) begin
      cur.delete(); exp_to++; exp_errs++;
    end
    if (cur.size() == 0 && b[7:5] != HEADER) begin
      exp_hdr++; exp_errs++;
      return;
    end
    cur.push_back(b);
    if (cur.size() == NB) begin
      p = 0;
      foreach (cur[i]) p = (p << 8) | int'(cur[i]);
      loc  = (p >> (DATA_W + 3)) % (1 << LOC_W);
      data = (p >> 3) % (1 << DATA_W);
      f    = p % 8;
      if (f != footer_of(loc, data)) begin
        exp_ftr++; exp_errs++;
      end else if (loc >= NUM_WORDS) begin
        exp_rng++; exp_errs++;
      end else begin
        exp_wr.push_back((LOC_W+DATA_W)'((loc << DATA_W) | data));
        exp_pkt++;
        if (exp_pkt == NUM_WORDS) done_m = 1;
      end
      cur.delete();
    end
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    idle_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) idle();
    model_byte(b, idle_cnt);
    idle_cnt = 0;
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int gap_first, input int max_gap);
    for (int k = NB - 1; k >= 0; k--)
      send_byte(8'((p >> (8*k)) & 255), (k == NB - 1) ? gap_first : int'($urandom_range(0, max_gap)));
  endtask

  task automatic do_clear(input bit with_byte, input logic [7:0] b);
    clear = 1'b1; in_valid = with_byte; in_byte = b;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    idle_cnt = 0;
  endtask

  task automatic check_counts(input string tag);
    repeat (3) idle();
    if (cur.size() > 0 && idle_cnt >= TIMEOUT) begin
      cur.delete(); exp_to++; exp_errs++;
    end
    check({tag, "_pkt"}, pkt_count, exp_pkt);
    check({tag, "_hdr"}, err_hdr_cnt, exp_hdr);
    check({tag, "_ftr"}, err_ftr_cnt, exp_ftr);
    check({tag, "_rng"}, err_rng_cnt, exp_rng);
    check({tag, "_to"}, err_to_cnt, exp_to);
    check({tag, "_pulses"}, obs_err - err_base, exp_errs);
    check({tag, "_wr_pending"}, exp_wr.size(), 0);
  endtask

  // Write/strobe monitor, sampled on the falling edge.
  logic wr_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", wr_addr, 32'(exp_wr[0] >> DATA_W));
          check("wr_data", wr_data, 32'(exp_wr[0] % (1 << DATA_W)));
          void'(exp_wr.pop_front());
        end
        check("wr_one_cycle", wr_prev, 0);
        check("wr_err_overlap", err_pulse, 0);
      end
      if (err_pulse) obs_err++;
      wr_prev <= wr_en;
    end else begin
      wr_prev <= 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int p, kind;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_byte = 8'h00; idle_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_errs", err_hdr_cnt | err_ftr_cnt | err_rng_cnt | err_to_cnt, 0);
    check("rst_flags", {err_pulse, busy, frame_done}, 0);
    rst = 1'b1;
    idle(); idle();
    model_reset();

    // Single good packet: loc 0, data 3C, latency and one-cycle strobe.
    p = mk_pkt(0, 8'h3C, -1);
    send_byte(8'(p >> 16), 1);
    check("t1_busy", busy, 1);
    send_byte(8'(p >> 8), 0);
    send_byte(8'(p), 2);
    check("t1_lat_e", wr_en, 0);
    idle();
    check("t1_wr_en", wr_en, 1);
    check("t1_addr", wr_addr, 0);
    check("t1_data", wr_data, 8'h3C);
    idle();
    check("t1_wr_off", wr_en, 0);
    check("t1_hold", wr_data, 8'h3C);
    check_counts("t1");

    // Footer bit 0 flipped, then a good packet.
    send_pkt(mk_pkt(5, 8'hA7, 0), 1, 1);
    idle();
    check("t3_pulse_on", err_pulse, 1);
    idle();
    check("t3_pulse_off", err_pulse, 0);
    send_pkt(mk_pkt(6, 8'h11, -1), 0, 2);
    check_counts("t3");

    // Stray byte resync.
    send_byte(8'h45, 1);
    send_pkt(mk_pkt(7, 8'h5A, -1), 0, 1);
    check_counts("t4");

    // Timeout boundary: 4095 idle cycles survive, 4096 drop the partial packet.
    p = mk_pkt(8, 8'h21, -1);
    send_byte(8'(p >> 16), 1);
    send_byte(8'(p >> 8), 0);
    send_byte(8'(p), TIMEOUT - 1);
    p = mk_pkt(9, 8'h9C, -1);
    send_byte(8'(p >> 16), 1);
    send_byte(8'(p >> 8), 0);
    repeat (TIMEOUT) idle();
    check("t5_to_busy", busy, 0);
    send_pkt(mk_pkt(10, 8'hC3, -1), 0, 1);
    send_pkt(mk_pkt(800, 8'h44, -1), 2, 1);
    check_counts("t5");

    // Random mix of good, out-of-range, bad-footer packets and stray bytes.
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        b = 8'($urandom_range(0, 255));
        while (b[7:5] == HEADER) b = 8'($urandom_range(0, 255));
        send_byte(b, 1 + $urandom_range(0, 2));
      end else if (kind == 1) begin
        send_pkt(mk_pkt($urandom_range(0, 1023), $urandom_range(0, 255), $urandom_range(0, 2)),
                 $urandom_range(0, 2), 2);
      end else begin
        send_pkt(mk_pkt($urandom_range(0, 1023), $urandom_range(0, 255), -1),
                 $urandom_range(0, 2), 2);
      end
    end
    check_counts("rand");

    // clear together with a mid-packet byte.
    p = mk_pkt(12, 8'h66, -1);
    send_byte(8'(p >> 16), 1);
    do_clear(1'b1, 8'(p >> 8));
    check("t6_clr_busy", busy, 0);
    check("t6_clr_cnt", pkt_count | err_hdr_cnt | err_ftr_cnt | err_rng_cnt | err_to_cnt, 0);
    send_pkt(mk_pkt(13, 8'h77, -1), 1, 1);
    check_counts("t6clr");

    // Full frame, then an extra packet that must be ignored.
    do_clear(1'b0, 8'h00);
    for (int l = 0; l < NUM_WORDS; l++)
      send_pkt(mk_pkt(l, $urandom_range(0, 255), -1), $urandom_range(0, 1), 1);
    check_counts("t2");
    check("t2_done", frame_done, 1);
    check("t2_busy", busy, 0);
    send_pkt(mk_pkt(3, 8'h12, -1), 0, 1);
    send_byte(8'h45, 1);
    check_counts("t2_extra");
    check("t2_done_hold", frame_done, 1);
    do_clear(1'b0, 8'h00);
    check("t2_clr_done", frame_done, 0);

    // Async reset mid-packet.
    send_pkt(mk_pkt(1, 8'h01, 1), 1, 1);
    check_counts("t6pre");
    p = mk_pkt(14, 8'h88, -1);
    send_byte(8'(p >> 16), 1);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", pkt_count | err_hdr_cnt | err_ftr_cnt | err_rng_cnt | err_to_cnt, 0);
    check("t6_rst_out", {wr_en, err_pulse, frame_done, wr_addr, wr_data}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    idle_cnt = 0;
    send_pkt(mk_pkt(15, 8'h99, -1), 1, 1);
    check_counts("t6rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
